// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types, frame constants and PCM conversion for adc_spi_sampler.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, MCP3202 frame layout constants, command-bit and PCM helpers.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_GAP,
    PUBLISH
  } state_e;

  localparam int ADC_BITS       = 12;
  localparam int PCM_BITS       = 16;
  localparam int FRAME_BITS     = 18;
  localparam int DATA_FIRST_IDX = 5;
  localparam int DATA_LAST_IDX  = 16;

  // Command header sent MSB first at SCLK indices 0..3; index 2 carries the channel.
  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  // MOSI level for a given channel and SCLK index; everything after the header is 0.
  function automatic logic cmd_bit(input logic ch, input logic [4:0] idx);
    logic b;
    case (idx)
      5'd0:    b = CMD_START;
      5'd1:    b = CMD_SGL;
      5'd2:    b = ch;
      5'd3:    b = CMD_MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Offset-binary 12-bit to two's-complement 16-bit: flip the MSB, left-justify.
  function automatic logic [PCM_BITS-1:0] adc_to_pcm(input logic [ADC_BITS-1:0] d);
    return {~d[ADC_BITS-1], d[ADC_BITS-2:0], 4'b0000};
  endfunction

endpackage

// File: rtl/adc_dc_blocker.sv
// adc_dc_blocker: first-order DC blocking high-pass for one PCM channel.
// Latency: combinational y_out from x_in; history registers advance only when en=1.
// Backpressure: none; en is a single-cycle update pulse from the sampler.
// Only compiled when ADC_DC_FILTER_EN is defined, so the default build carries no filter.
// Ports: clk, reset_n (async active-low), en (history update), x_in (signed PCM), y_out (filtered PCM).
`ifdef ADC_DC_FILTER_EN
module adc_dc_blocker #(
  parameter int DC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] x_in,
  output logic [15:0] y_out
);

  logic [15:0]        x_prev_q, x_prev_d;
  logic [15:0]        y_prev_q, y_prev_d;
  logic signed [17:0] x_ext, xp_ext, yp_ext, acc;

  // y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT) in 18 bits, then clamp to 16 bits.
  always_comb begin
    x_ext  = $signed({{2{x_in[15]}}, x_in});
    xp_ext = $signed({{2{x_prev_q[15]}}, x_prev_q});
    yp_ext = $signed({{2{y_prev_q[15]}}, y_prev_q});
    acc    = x_ext - xp_ext + yp_ext - (yp_ext >>> DC_SHIFT);
    if (acc > 18'sd32767) begin
      y_out = 16'h7FFF;
    end else if (acc < -18'sd32768) begin
      y_out = 16'h8000;
    end else begin
      y_out = acc[15:0];
    end
    x_prev_d = en ? x_in  : x_prev_q;
    y_prev_d = en ? y_out : y_prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else begin
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
    end
  end

endmodule
`endif

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic two-channel MCP3202 SPI read, published as signed 16-bit stereo PCM.
// Latency: tick to sample_strobe = 78*SCLK_HALF + 1 clk cycles (625 at defaults).
// Backpressure: none; a tick arriving while a frame is in flight is dropped and sets sticky overrun.
// Optional feature: `define ADC_DC_FILTER_EN inserts an adc_dc_blocker per channel before publishing.
// Ports: clk, reset_n (async active-low), sample_en (tick counter run), adc_clk/adc_cs/adc_mosi (SPI out),
//        adc_miso (SPI in, async), audio_sample_word[1:0] ([0]=left/ch0, [1]=right/ch1),
//        sample_strobe (1-cycle update pulse), overrun (sticky dropped-tick flag).
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int SAMPLE_DIV = 1125,
  parameter int SCLK_HALF  = 8,
  parameter int DC_SHIFT   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_en,
  output logic             adc_clk,
  output logic             adc_cs,
  output logic             adc_mosi,
  input  logic             adc_miso,
  output logic [1:0][15:0] audio_sample_word,
  output logic             sample_strobe,
  output logic             overrun
);

  if (SAMPLE_DIV < 1 || SCLK_HALF < 2 || SCLK_HALF > 255 || DC_SHIFT < 1 || DC_SHIFT > 15) begin : g_cfg_check
    $error("adc_spi_sampler: parameter out of range");
  end

  localparam int                DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [8:0]        HALF_LAST = 9'(SCLK_HALF - 1);
  localparam logic [8:0]        GAP_LAST  = 9'(2 * SCLK_HALF - 1);
  localparam logic [4:0]        IDX_LAST  = 5'(FRAME_BITS - 1);
  localparam logic [4:0]        CAP_FIRST = 5'(DATA_FIRST_IDX);
  localparam logic [4:0]        CAP_LAST  = 5'(DATA_LAST_IDX);

  // Sample tick generator.
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  // Frame sequencer state.
  state_e           state_q, state_d;
  logic             ch_q, ch_d;
  logic [8:0]       half_cnt_q, half_cnt_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [11:0]      shreg_q, shreg_d;
  logic [11:0]      raw0_q, raw0_d;

  // Registered pin and output state.
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [1:0][15:0] word_q, word_d;
  logic             strobe_q, strobe_d;
  logic             overrun_q, overrun_d;

  // Two-flop MISO synchroniser.
  logic             miso_s1_q, miso_s1_d;
  logic             miso_s2_q, miso_s2_d;

  // Values that will be written into the output words on the next publish.
  logic [15:0]      pcm_l, pcm_r;
  logic [15:0]      pub_l, pub_r;
  logic             publish_go;

  assign tick = sample_en && (tick_cnt_q == DIV_LAST);

  // Last cycle of the ch1 gap: the edge that enters PUBLISH and loads the words.
  assign publish_go = (state_q == CS_GAP) && (half_cnt_q == GAP_LAST) && ch_q;

  // raw0_q holds ch0; ch1 is still sitting in the shift register at publish time.
  assign pcm_l = adc_to_pcm(raw0_q);
  assign pcm_r = adc_to_pcm(shreg_q);

`ifdef ADC_DC_FILTER_EN
  adc_dc_blocker #(.DC_SHIFT(DC_SHIFT)) u_dc_l (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (publish_go),
    .x_in    (pcm_l),
    .y_out   (pub_l)
  );

  adc_dc_blocker #(.DC_SHIFT(DC_SHIFT)) u_dc_r (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (publish_go),
    .x_in    (pcm_r),
    .y_out   (pub_r)
  );
`else
  assign pub_l = pcm_l;
  assign pub_r = pcm_r;
`endif

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    state_d    = state_q;
    ch_d       = ch_q;
    half_cnt_d = half_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    raw0_d     = raw0_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    word_d     = word_q;
    strobe_d   = 1'b0;
    miso_s1_d  = adc_miso;
    miso_s2_d  = miso_s1_q;
    // Any tick outside IDLE (including the PUBLISH cycle) is lost.
    overrun_d  = overrun_q | (tick && (state_q != IDLE));

    if (sample_en) begin
      tick_cnt_d = (tick_cnt_q == DIV_LAST) ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d    = CS_SETUP;
          ch_d       = 1'b0;
          half_cnt_d = '0;
          cs_d       = 1'b0;
          sclk_d     = 1'b0;
          mosi_d     = cmd_bit(1'b0, 5'd0);
        end
      end

      CS_SETUP: begin
        if (half_cnt_q == HALF_LAST) begin
          state_d    = SHIFT;
          half_cnt_d = '0;
          bit_idx_d  = '0;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (half_cnt_q != HALF_LAST) begin
          half_cnt_d = half_cnt_q + 1'b1;
        end else begin
          half_cnt_d = '0;
          if (!sclk_q) begin
            // Rising edge. miso_s2_q reflects the pin as seen SCLK_HALF-1 cycles after the
            // falling edge, which leaves the synchroniser time to settle.
            sclk_d = 1'b1;
            if (bit_idx_q >= CAP_FIRST && bit_idx_q <= CAP_LAST) begin
              shreg_d = {shreg_q[10:0], miso_s2_q};
            end
          end else if (bit_idx_q == IDX_LAST) begin
            state_d = CS_GAP;
            sclk_d  = 1'b0;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
          end else begin
            // Falling edge: MOSI moves only here so it is stable across the next rise.
            sclk_d    = 1'b0;
            bit_idx_d = bit_idx_q + 1'b1;
            mosi_d    = cmd_bit(ch_q, 5'(bit_idx_q + 1'b1));
          end
        end
      end

      CS_GAP: begin
        if (half_cnt_q != GAP_LAST) begin
          half_cnt_d = half_cnt_q + 1'b1;
        end else begin
          half_cnt_d = '0;
          if (!ch_q) begin
            raw0_d  = shreg_q;
            ch_d    = 1'b1;
            state_d = CS_SETUP;
            cs_d    = 1'b0;
            mosi_d  = cmd_bit(1'b1, 5'd0);
          end else begin
            // Words and strobe are registered here so both are visible in the PUBLISH cycle.
            state_d   = PUBLISH;
            word_d[0] = pub_l;
            word_d[1] = pub_r;
            strobe_d  = 1'b1;
          end
        end
      end

      PUBLISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      ch_q       <= 1'b0;
      half_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      raw0_q     <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      word_q     <= '0;
      strobe_q   <= 1'b0;
      overrun_q  <= 1'b0;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      ch_q       <= ch_d;
      half_cnt_q <= half_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      raw0_q     <= raw0_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      word_q     <= word_d;
      strobe_q   <= strobe_d;
      overrun_q  <= overrun_d;
      miso_s1_q  <= miso_s1_d;
      miso_s2_q  <= miso_s2_d;
    end
  end

  assign adc_cs            = cs_q;
  assign adc_clk           = sclk_q;
  assign adc_mosi          = mosi_q;
  assign audio_sample_word = word_q;
  assign sample_strobe     = strobe_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: drives adc_spi_sampler against a behavioural MCP3202 model and checks
// frame shape, command bits, PCM words, strobe timing, overrun and mid-frame reset.
// A second instance with SAMPLE_DIV=500 exercises the overrun path.
module tb_adc_spi_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             sample_en;
  logic             adc_clk, adc_cs, adc_mosi, adc_miso;
  logic [1:0][15:0] audio_sample_word;
  logic             sample_strobe, overrun;

  logic             b_adc_clk, b_adc_cs, b_adc_mosi, b_miso;
  logic [1:0][15:0] b_words;
  logic             b_strobe, b_overrun;

  assign b_miso = 1'b0;

  adc_spi_sampler u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .sample_en         (sample_en),
    .adc_clk           (adc_clk),
    .adc_cs            (adc_cs),
    .adc_mosi          (adc_mosi),
    .adc_miso          (adc_miso),
    .audio_sample_word (audio_sample_word),
    .sample_strobe     (sample_strobe),
    .overrun           (overrun)
  );

  adc_spi_sampler #(.SAMPLE_DIV(500)) u_ovr (
    .clk               (clk),
    .reset_n           (reset_n),
    .sample_en         (sample_en),
    .adc_clk           (b_adc_clk),
    .adc_cs            (b_adc_cs),
    .adc_mosi          (b_adc_mosi),
    .adc_miso          (b_miso),
    .audio_sample_word (b_words),
    .sample_strobe     (b_strobe),
    .overrun           (b_overrun)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model values per channel, and monitor logs.
  logic [11:0] m_val [0:1];
  logic        m_ch = 1'b0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic        in_frame = 1'b0;
  int          cur_rises = 0;
  logic [3:0]  cur_cmd = 4'b0;
  logic        tail_zero = 1'b1;
  int          fall_q[$], rise_q[$], rises_q[$];
  logic [3:0]  cmd_q[$];
  logic        tail_q[$];
  int          strobe_cyc_q[$];
  logic [15:0] strobe_w0_q[$], strobe_w1_q[$];

  logic             b_prev_cs = 1'b1, b_prev_sclk = 1'b0, b_in = 1'b0;
  int               b_rise_total = 0, b_frames = 0, b_mosi_ones = 0;
  int               b_strobe_q[$];
  int               b_snap_rises = 0, b_snap_frames = 0, b_snap_ones = 0;
  logic [1:0][15:0] b_snap_w = '0;
  int               b_ovr_set_cyc = -1;

  // Behavioural ADC + bus monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      cur_rises = 0;
      adc_miso = 1'b0;
      b_in = 1'b0;
    end else begin
      if (!adc_cs && prev_cs) begin
        in_frame = 1'b1; cur_rises = 0; cur_cmd = 4'b0; tail_zero = 1'b1;
        m_ch = 1'b0; adc_miso = 1'b0;
        fall_q.push_back(cyc);
      end
      if (in_frame && adc_clk && !prev_sclk) begin
        if (cur_rises < 4) cur_cmd[3-cur_rises] = adc_mosi;
        else if (adc_mosi) tail_zero = 1'b0;
        if (cur_rises == 2) m_ch = adc_mosi;
        cur_rises++;
      end
      if (in_frame && !adc_clk && prev_sclk) begin
        // Next bit index is cur_rises; result bits occupy indices 5..16, MSB first.
        if (cur_rises >= 5 && cur_rises <= 16) adc_miso = m_val[m_ch][16-cur_rises];
        else adc_miso = 1'b0;
      end
      if (in_frame && adc_cs && !prev_cs) begin
        in_frame = 1'b0;
        rise_q.push_back(cyc); rises_q.push_back(cur_rises);
        cmd_q.push_back(cur_cmd); tail_q.push_back(tail_zero);
      end
      if (sample_strobe) begin
        strobe_cyc_q.push_back(cyc);
        strobe_w0_q.push_back(audio_sample_word[0]);
        strobe_w1_q.push_back(audio_sample_word[1]);
      end

      if (!b_adc_cs && b_prev_cs) b_in = 1'b1;
      if (b_in && b_adc_clk && !b_prev_sclk) begin
        b_rise_total++;
        if (b_adc_mosi) b_mosi_ones++;
      end
      if (b_in && b_adc_cs && !b_prev_cs) begin b_in = 1'b0; b_frames++; end
      if (b_strobe) begin
        b_strobe_q.push_back(cyc);
        if (b_strobe_q.size() == 1) begin
          b_snap_rises = b_rise_total; b_snap_frames = b_frames;
          b_snap_ones = b_mosi_ones; b_snap_w = b_words;
        end
      end
      if (b_overrun && b_ovr_set_cyc < 0) b_ovr_set_cyc = cyc;
    end
    prev_cs = adc_cs; prev_sclk = adc_clk;
    b_prev_cs = b_adc_cs; b_prev_sclk = b_adc_clk;
  end

  // Offset-binary code to signed PCM: centre at 2048, scale by 16.
  function automatic logic [15:0] ref_pcm(input int v);
    return 16'((v - 2048) * 16);
  endfunction

  int e_cyc;

  task automatic test_reset();
    reset_n = 1'b0; sample_en = 1'b0;
    m_val[0] = 12'h000; m_val[1] = 12'h000;
    repeat (5) @(negedge clk);
    checks++; if (adc_cs !== 1'b1) begin errs++; $display("FAIL reset_cs: got %b want 1", adc_cs); end
    checks++; if (adc_clk !== 1'b0) begin errs++; $display("FAIL reset_sclk: got %b want 0", adc_clk); end
    checks++; if (adc_mosi !== 1'b0) begin errs++; $display("FAIL reset_mosi: got %b want 0", adc_mosi); end
    checks++; if (audio_sample_word !== 32'h0) begin errs++; $display("FAIL reset_words: got %h want 0", audio_sample_word); end
    checks++; if (sample_strobe !== 1'b0) begin errs++; $display("FAIL reset_strobe: got %b want 0", sample_strobe); end
    checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_idle();
    reset_n = 1'b1;
    repeat (2500) @(negedge clk);
    checks++; if (fall_q.size() != 0) begin errs++; $display("FAIL idle_cs: got %0d frames want 0", fall_q.size()); end
    checks++; if (strobe_cyc_q.size() + b_strobe_q.size() != 0) begin
      errs++; $display("FAIL idle_strobe: got %0d strobes want 0", strobe_cyc_q.size() + b_strobe_q.size());
    end
  endtask

  task automatic test_capture();
    logic [15:0] exp_w0, exp_w1;
    int prev_s, s;
    logic got;
    m_val[0] = 12'hFFF; m_val[1] = 12'h000;
    @(negedge clk); sample_en = 1'b1; e_cyc = cyc;
    prev_s = e_cyc + 1749 - 1125;
    for (int k = 0; k < 5; k++) begin
      exp_w0 = ref_pcm(int'(m_val[0])); exp_w1 = ref_pcm(int'(m_val[1]));
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
        @(negedge clk);
        if (strobe_cyc_q.size() > 0) got = 1'b1;
      end
      checks++;
      if (!got) begin errs++; $display("FAIL cap_timeout pair %0d: no strobe within 3000 cycles", k); return; end
      s = strobe_cyc_q.pop_front();
      checks++; if (s != prev_s + 1125) begin errs++; $display("FAIL cap_strobe_cyc pair %0d: got %0d want %0d", k, s, prev_s + 1125); end
      prev_s = s;
      checks++; if (strobe_w0_q[0] !== exp_w0) begin errs++; $display("FAIL cap_left pair %0d: got %h want %h", k, strobe_w0_q[0], exp_w0); end
      checks++; if (strobe_w1_q[0] !== exp_w1) begin errs++; $display("FAIL cap_right pair %0d: got %h want %h", k, strobe_w1_q[0], exp_w1); end
      void'(strobe_w0_q.pop_front()); void'(strobe_w1_q.pop_front());
      checks++;
      if (rises_q.size() < 2) begin errs++; $display("FAIL cap_frames pair %0d: got %0d frames want 2", k, rises_q.size()); return; end
      checks++; if (rises_q[0] != 18 || rises_q[1] != 18) begin
        errs++; $display("FAIL cap_rises pair %0d: got %0d/%0d want 18/18", k, rises_q[0], rises_q[1]);
      end
      checks++; if (cmd_q[0] !== 4'b1101 || cmd_q[1] !== 4'b1111) begin
        errs++; $display("FAIL cap_cmd pair %0d: got %b/%b want 1101/1111", k, cmd_q[0], cmd_q[1]);
      end
      checks++; if (tail_q[0] !== 1'b1 || tail_q[1] !== 1'b1) begin
        errs++; $display("FAIL cap_mosi_tail pair %0d: got %b/%b want 1/1", k, tail_q[0], tail_q[1]);
      end
      checks++; if (fall_q[1] - rise_q[0] != 16) begin
        errs++; $display("FAIL cap_cs_gap pair %0d: got %0d want 16", k, fall_q[1] - rise_q[0]);
      end
      for (int j = 0; j < 2; j++) begin
        void'(fall_q.pop_front()); void'(rise_q.pop_front()); void'(rises_q.pop_front());
        void'(cmd_q.pop_front()); void'(tail_q.pop_front());
      end
      if (k == 0) begin m_val[0] = 12'h800; m_val[1] = 12'h7FF; end
      else begin m_val[0] = 12'($urandom_range(0, 4095)); m_val[1] = 12'($urandom_range(0, 4095)); end
    end
  endtask

  task automatic test_overrun();
    checks++; if (b_strobe_q.size() < 2) begin errs++; $display("FAIL ovr_strobes: got %0d want >=2", b_strobe_q.size()); return; end
    checks++; if (b_strobe_q[0] != e_cyc + 1124) begin errs++; $display("FAIL ovr_first_strobe: got %0d want %0d", b_strobe_q[0], e_cyc + 1124); end
    checks++; if (b_strobe_q[1] - b_strobe_q[0] != 1000) begin errs++; $display("FAIL ovr_period: got %0d want 1000", b_strobe_q[1] - b_strobe_q[0]); end
    checks++; if (b_ovr_set_cyc != e_cyc + 1000) begin errs++; $display("FAIL ovr_set_cyc: got %0d want %0d", b_ovr_set_cyc, e_cyc + 1000); end
    checks++; if (b_overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky: got %b want 1", b_overrun); end
    checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_main_clear: got %b want 0", overrun); end
    checks++; if (b_snap_rises != 36 || b_snap_frames != 2 || b_snap_ones != 7) begin
      errs++; $display("FAIL ovr_frames: got rises %0d frames %0d ones %0d want 36 2 7", b_snap_rises, b_snap_frames, b_snap_ones);
    end
    checks++; if (b_snap_w !== {16'h8000, 16'h8000}) begin errs++; $display("FAIL ovr_words: got %h want 80008000", b_snap_w); end
  endtask

  task automatic test_reset_mid_frame();
    logic got;
    int e2;
    logic [15:0] exp_w0, exp_w1;
    m_val[0] = 12'($urandom_range(0, 4095)); m_val[1] = 12'($urandom_range(0, 4095));
    exp_w0 = ref_pcm(int'(m_val[0])); exp_w1 = ref_pcm(int'(m_val[1]));
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (in_frame && cur_rises == 9 && adc_clk == 1'b0) got = 1'b1;
    end
    checks++;
    if (!got) begin errs++; $display("FAIL rst_wait_idx9: frame index 9 not reached"); return; end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (adc_cs !== 1'b1) begin errs++; $display("FAIL rst_mid_cs: got %b want 1", adc_cs); end
    checks++; if (adc_clk !== 1'b0) begin errs++; $display("FAIL rst_mid_sclk: got %b want 0", adc_clk); end
    checks++; if (audio_sample_word !== 32'h0) begin errs++; $display("FAIL rst_mid_words: got %h want 0", audio_sample_word); end
    checks++; if (b_overrun !== 1'b0) begin errs++; $display("FAIL rst_mid_overrun: got %b want 0", b_overrun); end
    strobe_cyc_q.delete(); strobe_w0_q.delete(); strobe_w1_q.delete();
    fall_q.delete(); rise_q.delete(); rises_q.delete(); cmd_q.delete(); tail_q.delete();
    repeat (5) @(negedge clk);
    reset_n = 1'b1; e2 = cyc;
    while (cyc < e2 + 1000) @(negedge clk);
    checks++; if (audio_sample_word !== 32'h0) begin errs++; $display("FAIL rst_hold_words: got %h want 0", audio_sample_word); end
    checks++; if (strobe_cyc_q.size() != 0) begin errs++; $display("FAIL rst_early_strobe: got %0d want 0", strobe_cyc_q.size()); end
    got = 1'b0;
    for (int t = 0; t < 1500 && !got; t++) begin
      @(negedge clk);
      if (strobe_cyc_q.size() > 0) got = 1'b1;
    end
    checks++;
    if (!got) begin errs++; $display("FAIL rst_fresh_timeout: no strobe after reset"); return; end
    checks++; if (strobe_cyc_q[0] != e2 + 1749) begin errs++; $display("FAIL rst_fresh_cyc: got %0d want %0d", strobe_cyc_q[0], e2 + 1749); end
    checks++; if (strobe_w0_q[0] !== exp_w0 || strobe_w1_q[0] !== exp_w1) begin
      errs++; $display("FAIL rst_fresh_words: got %h/%h want %h/%h", strobe_w0_q[0], strobe_w1_q[0], exp_w0, exp_w1);
    end
    checks++; if (rises_q.size() < 1 || rises_q[0] != 18) begin errs++; $display("FAIL rst_fresh_rises: first frame not 18 rises"); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_capture();
    test_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errs);
    $fatal(1);
  end

endmodule
